// File: rtl/uart_pkg.sv
// Shared UART frame constants, dump FSM state type and bit-period helper.
// The CHK state exists only when DUMP_CHKSUM_EN is defined.
package uart_pkg;

  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
    StStop,
    StNext
`ifdef DUMP_CHKSUM_EN
    ,
    StChk
`endif
  } state_e;

  // Truncating divide; callers guarantee the result is at least 2.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: owns the baud counter and bit shifter.
// A load in the last stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic       near_end_o
);

  localparam int unsigned     CntW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned     FrameLen = FRAME_BITS * DIV;
  localparam int unsigned     RemW     = $clog2(FrameLen);
  localparam logic [CntW-1:0] CntLast  = CntW'(DIV - 1);
  localparam logic [3:0]      BitLast  = 4'(FRAME_BITS - 1);

  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS:0]   shift_q, shift_d;
  logic [RemW-1:0]      rem_q, rem_d;
  logic                 bit_end;

  assign bit_end     = busy_q && (cnt_q == CntLast);
  assign byte_done_o = bit_end && (bit_q == BitLast);
  // Two cycles of frame left: lets the word fetch overlap the tail of the stop bit.
  assign near_end_o  = busy_q && (rem_q == RemW'(2));
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;

  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    if (clr_i) begin
      busy_d = 1'b0;
      tx_d   = STOP_BIT;
    end else if (load_i && (!busy_q || byte_done_o)) begin
      busy_d  = 1'b1;
      tx_d    = START_BIT;
      shift_d = {STOP_BIT, byte_i};
      cnt_d   = '0;
      bit_d   = '0;
      rem_d   = RemW'(FrameLen - 1);
    end else if (busy_q) begin
      rem_d = rem_q - RemW'(1);
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == BitLast) begin
          busy_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {STOP_BIT, shift_q[DATA_BITS:1]};
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q  <= 1'b0;
      tx_q    <= STOP_BIT;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      rem_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Memory dump transmitter: fetches 32-bit words and sends them LSB byte first over 8N1.
// Define DUMP_CHKSUM_EN to append a modulo-256 checksum byte after the last word.
module mem_dump_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 128_000,
  parameter int unsigned ADR_W    = 14
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ADR_W-1:0] base_adr_i,
  input  logic [ADR_W:0]   word_cnt_i,
  output logic             mem_ren_o,
  output logic [ADR_W-1:0] mem_adr_o,
  input  logic [31:0]      mem_dat_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned  DIV     = calc_div(CLK_FREQ, BAUD);
  localparam logic [ADR_W:0] OneWord = (ADR_W + 1)'(1);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [ADR_W:0]   left_q, left_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic             load;
  logic [7:0]       load_byte;
  logic             kill;
  logic             tx_busy;
  logic             byte_done;
  logic             near_end;

  assign kill = abort_i && (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    left_d    = left_q;
    word_d    = word_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_byte = word_q[7:0];
`ifdef DUMP_CHKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i && !done_q && !tx_busy) begin
          if (word_cnt_i != '0) begin
            adr_d   = base_adr_i;
            left_d  = word_cnt_i;
            state_d = StFetch;
`ifdef DUMP_CHKSUM_EN
            sum_d   = '0;
`endif
          end else begin
`ifdef DUMP_CHKSUM_EN
            load      = 1'b1;
            load_byte = '0;
            sum_d     = '0;
            state_d   = StChk;
`else
            done_d    = 1'b1;
`endif
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        word_d  = mem_dat_i;
        idx_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        load    = 1'b1;
        word_d  = {8'h00, word_q[31:8]};
`ifdef DUMP_CHKSUM_EN
        sum_d   = sum_q + word_q[7:0];
`endif
        state_d = StData;
      end
      StData: begin
        if (byte_done) begin
          load   = 1'b1;
          word_d = {8'h00, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
`ifdef DUMP_CHKSUM_EN
          sum_d  = sum_q + word_q[7:0];
`endif
          if (idx_q == 2'd2) state_d = StStop;
        end
      end
      // Byte 3 is in flight; decide early so only two idle cycles separate words.
      StStop: begin
        if (left_q != OneWord) begin
          if (near_end) begin
            left_d  = left_q - OneWord;
            state_d = StNext;
          end
        end else if (byte_done) begin
`ifdef DUMP_CHKSUM_EN
          load      = 1'b1;
          load_byte = sum_q;
          state_d   = StChk;
`else
          done_d    = 1'b1;
          state_d   = StIdle;
`endif
        end
      end
      StNext: begin
        adr_d   = adr_q + 1'b1;
        state_d = StFetch;
      end
`ifdef DUMP_CHKSUM_EN
      StChk: begin
        if (byte_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (kill) begin
      state_d = StIdle;
      done_d  = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      left_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      left_q  <= left_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef DUMP_CHKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (kill),
    .load_i      (load),
    .byte_i      (load_byte),
    .tx_o        (tx_o),
    .busy_o      (tx_busy),
    .byte_done_o (byte_done),
    .near_end_o  (near_end)
  );

  assign mem_ren_o = (state_q == StFetch);
  assign mem_adr_o = adr_q;
  assign busy_o    = (state_q != StIdle) || done_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx at DIV=4: logs every cycle of a dump and
// compares it against a hand-built expected tx waveform and handshake timing.
module tb_mem_dump_tx;

  localparam int LOGLEN = 420;
`ifdef DUMP_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [13:0] base_adr_i = '0;
  logic [14:0] word_cnt_i = '0;
  logic        mem_ren_o;
  logic [13:0] mem_adr_o;
  logic [31:0] mem_dat_i = '0;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic        tx_log   [LOGLEN];
  logic        busy_log [LOGLEN];
  logic        done_log [LOGLEN];
  logic        exp_tx   [LOGLEN];
  int          exp_done;
  logic [31:0] xw [$];
  logic [13:0] xa [$];
  logic [13:0] got_adr [$];

  always #5 clk = ~clk;

  mem_dump_tx #(
    .CLK_FREQ (400),
    .BAUD     (100),
    .ADR_W    (14)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .base_adr_i (base_adr_i),
    .word_cnt_i (word_cnt_i),
    .mem_ren_o  (mem_ren_o),
    .mem_adr_o  (mem_adr_o),
    .mem_dat_i  (mem_dat_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    case (a)
      14'h0010: return 32'h4433_2211;
      14'h3FFF: return 32'hA5C3_0F81;
      14'h0000: return 32'h1234_5678;
      14'h0020: return 32'h0000_00FF;
      14'h0021: return 32'h0000_0002;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Data is only valid the cycle after a read strobe.
  always @(posedge clk) mem_dat_i <= mem_ren_o ? mem_word(mem_adr_o) : 32'hBAD0_BAD0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_byte(input int s, input logic [7:0] b);
    for (int c = 0; c < 4; c++) exp_tx[s + c] = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 4; c++) exp_tx[s + 4 * (i + 1) + c] = b[i];
  endtask

  // Byte j starts at cycle 3 + 40*j, plus 2 idle cycles per word boundary.
  task automatic build_exp(input logic [7:0] chk);
    int nb;
    int e;
    logic [31:0] w;
    nb = 4 * xw.size();
    for (int k = 0; k < LOGLEN; k++) exp_tx[k] = 1'b1;
    for (int j = 0; j < nb; j++) begin
      w = xw[j / 4];
      put_byte(3 + 40 * j + 2 * (j / 4), w[8 * (j % 4) +: 8]);
    end
    e = (nb == 0) ? 0 : 3 + 40 * nb + 2 * (xw.size() - 1);
    if (CHK_EN) begin
      put_byte(e, chk);
      e += 40;
    end
    exp_done = e;
  endtask

  task automatic run_dump(input logic [13:0] base, input logic [14:0] cnt, input int len,
                          input int abort_at, input int poke_at);
    got_adr.delete();
    @(negedge clk);
    base_adr_i = base;
    word_cnt_i = cnt;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    base_adr_i = 14'h0123;
    word_cnt_i = 15'd7;
    for (int k = 0; k < len; k++) begin
      tx_log[k]   = tx_o;
      busy_log[k] = busy_o;
      done_log[k] = done_o;
      if (mem_ren_o) got_adr.push_back(mem_adr_o);
      abort_i = (k == abort_at);
      start_i = (k == poke_at);
      @(negedge clk);
    end
    abort_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_dump(input string tag, input int len);
    int bad;
    int ndone;
    int done_at;
    bad = 0;
    ndone = 0;
    done_at = -1;
    for (int k = 0; k < len; k++) begin
      if (tx_log[k] !== exp_tx[k]) bad++;
      if (done_log[k] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    check_eq({tag, " tx wrong cycles"}, bad, 0);
    check_eq({tag, " busy first cycle"}, 32'(busy_log[0]), 1);
    check_eq({tag, " done pulses"}, ndone, 1);
    check_eq({tag, " done cycle"}, done_at, exp_done);
    check_eq({tag, " busy at done"}, 32'(busy_log[exp_done]), 1);
    check_eq({tag, " busy after done"}, 32'(busy_log[exp_done + 1]), 0);
    check_eq({tag, " reads"}, got_adr.size(), xa.size());
    for (int i = 0; i < xa.size() && i < got_adr.size(); i++)
      check_eq($sformatf("%s read adr %0d", tag, i), 32'(got_adr[i]), 32'(xa[i]));
  endtask

  initial begin
    int z;
    int zeros;
    #1 reset_i = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset tx", 32'(tx_o), 1);
    check_eq("reset busy", 32'(busy_o), 0);
    check_eq("reset done", 32'(done_o), 0);
    check_eq("reset ren", 32'(mem_ren_o), 0);
    check_eq("reset adr", 32'(mem_adr_o), 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single word, 0x11 0x22 0x33 0x44; a start poked mid-dump must be ignored.
    xw = {32'h4433_2211};
    xa = {14'h0010};
    build_exp(8'hAA);
    run_dump(14'h0010, 15'd1, 260, -1, 50);
    check_dump("t1", 260);
    z = -1;
    for (int k = 0; k < 20; k++) if (z < 0 && tx_log[k] === 1'b0) z = k;
    check_eq("t1 first start bit cycle", z, 3);

    // 2: zero words.
    xw = {};
    xa = {};
    build_exp(8'h00);
    run_dump(14'h0010, 15'd0, 60, -1, -1);
    check_dump("t2", 60);

    // 3: address wrap 0x3FFF -> 0x0000 and two idle cycles between words.
    xw = {32'hA5C3_0F81, 32'h1234_5678};
    xa = {14'h3FFF, 14'h0000};
    build_exp(8'h0C);
    run_dump(14'h3FFF, 15'd2, 400, -1, -1);
    check_dump("t3", 400);
    z = -1;
    for (int k = 163; k < 200; k++) if (z < 0 && tx_log[k] === 1'b0) z = k;
    check_eq("t3 idle cycles between words", z - 163, 2);

    // 4: abort in data bit 3 of byte 0x22 (cycles 59..62), with a start in the same cycle.
    xw = {32'h4433_2211};
    xa = {14'h0010};
    build_exp(8'hAA);
    run_dump(14'h0010, 15'd1, 120, 60, 60);
    zeros = 0;
    for (int k = 0; k <= 60; k++) if (tx_log[k] !== exp_tx[k]) zeros++;
    check_eq("t4 tx before abort", zeros, 0);
    check_eq("t4 tx low at abort", 32'(tx_log[60]), 0);
    check_eq("t4 tx after abort", 32'(tx_log[61]), 1);
    check_eq("t4 busy after abort", 32'(busy_log[61]), 0);
    zeros = 0;
    for (int k = 61; k < 120; k++) if (tx_log[k] !== 1'b1 || done_log[k] !== 1'b0) zeros++;
    check_eq("t4 quiet after abort", zeros, 0);
    check_eq("t4 reads", got_adr.size(), 1);
    build_exp(8'hAA);
    run_dump(14'h0010, 15'd1, 260, -1, -1);
    check_dump("t4 restart", 260);

    // 5: asynchronous reset during the start bit.
    @(negedge clk);
    base_adr_i = 14'h0010;
    word_cnt_i = 15'd1;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5 tx low before reset", 32'(tx_o), 0);
    #2 reset_i = 1'b1;
    #1;
    check_eq("t5 tx async", 32'(tx_o), 1);
    check_eq("t5 busy async", 32'(busy_o), 0);
    check_eq("t5 done async", 32'(done_o), 0);
    check_eq("t5 ren async", 32'(mem_ren_o), 0);
    check_eq("t5 adr async", 32'(mem_adr_o), 0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // 6: bytes FF 00 00 00 02 00 00 00, checksum trailer 0x01 when enabled.
    xw = {32'h0000_00FF, 32'h0000_0002};
    xa = {14'h0020, 14'h0021};
    build_exp(8'h01);
    run_dump(14'h0020, 15'd2, 400, -1, -1);
    check_dump("t6", 400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
UART transmit engine: the outbound counterpart of the UART program loader. On a start request it reads a range of 32-bit words from a memory read port and serialises each word over UART 8N1, least-significant byte first. Sits beside the loader in the top level and drives the board tx pin when a memory or result dump is requested. The host side receives exactly the byte stream the loader would accept.

Parameters:
CLK_FREQ, 10_000_000, input clock frequency in Hz
BAUD, 128_000, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD (integer truncation, DIV >= 2)
ADR_W, 14, word-address width of the memory port

Ports:
clk_i  in  1  single clock, all logic on its rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  dump request, sampled only in IDLE
abort_i  in  1  cancel current dump
base_adr_i  in  ADR_W  first word address, latched on accepted start
word_cnt_i  in  ADR_W+1  number of words, latched on accepted start
mem_ren_o  out  1  memory read strobe, one cycle per word
mem_adr_o  out  ADR_W  memory word address
mem_dat_i  in  32  read data, valid exactly one cycle after mem_ren_o
tx_o  out  1  UART serial output, idle high
busy_o  out  1  dump in progress
done_o  out  1  one-cycle pulse at dump completion

Behaviour:
- Reset values: tx_o=1, busy_o=0, done_o=0, mem_ren_o=0, mem_adr_o=0, FSM=IDLE. Reset is asynchronous: tx_o returns high immediately, even in the middle of a bit.
- FSM states: IDLE, FETCH, WAIT, START, DATA, STOP, NEXT, plus CHK (optional feature only).
- IDLE:
  - start_i=1 with word_cnt_i!=0 -> FETCH; base and count are latched.
  - start_i=1 with word_cnt_i==0 -> done_o pulses on the next cycle; no read is issued and tx_o stays high.
- FETCH: mem_ren_o=1 and mem_adr_o=current address for exactly one cycle -> WAIT.
- WAIT: mem_dat_i is captured into the shift word; byte index is set to 0 -> START.
- Start-bit latency: start accepted at edge N, mem_ren_o high in cycle N+1, tx_o=0 from edge N+3.
- Each byte is 10 periods of DIV cycles: start 0, data bits 0..7 LSB first, stop 1.
- Bytes 0..3 of a word are sent back to back with no gap.
- NEXT (after byte 3 stop):
  - If words remain: address increments modulo 2^ADR_W (0x3FFF wraps to 0x0000) -> FETCH. This gives exactly 2 idle-high cycles between words.
  - Otherwise -> IDLE with done_o=1 for one cycle.
- busy_o is high from the cycle after start is accepted through the done_o cycle inclusive.
- abort_i in any non-IDLE state wins over every other event: next cycle FSM=IDLE, tx_o=1, busy_o=0, no done_o. A start_i high in that same cycle is ignored.
- start_i while busy is ignored. Latched base and count are unaffected by input changes mid-dump.
- The baud counter restarts at the beginning of every start bit; no fractional accumulation.

Optional Feature:
DUMP_CHKSUM_EN
- Defined:
  - After the last word, the CHK state sends one extra 8N1 byte: the 8-bit modulo-256 sum of all transmitted data bytes.
  - done_o pulses after that byte's stop bit.
  - For word_cnt_i==0 the checksum byte 0x00 is still sent.
- Undefined: no trailer byte and no CHK state; word_cnt_i==0 behaves as above.

Decomposition:
- Shared package (uart_pkg):
  - FSM state enum.
  - UART frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
  - Function computing DIV from CLK_FREQ/BAUD.
- One sub-module, uart_tx_byte:
  - Inputs: byte and a load strobe.
  - Outputs: tx, busy, and a one-cycle byte_done.
  - Owns the baud counter and bit shifter.
- mem_dump_tx keeps the word-fetch FSM, byte sequencing and checksum.

Test Plan:
1. CLK_FREQ=400, BAUD=100 (DIV=4), base=0x0010, count=1, mem[0x10]=0x44332211 -> tx carries 0x11,0x22,0x33,0x44; first start bit at cycle 3; 160 cycles of serial data; done_o pulses once; busy_o falls the cycle after.
2. count=0 -> done_o pulses 1 cycle after start; mem_ren_o never high; tx_o constantly 1 (with DUMP_CHKSUM_EN: the single byte 0x00).
3. base=0x3FFF, count=2 -> mem_adr_o 0x3FFF then 0x0000; exactly 2 high cycles between word 0 stop bit and word 1 start bit.
4. abort_i asserted during bit 3 of byte 1 -> tx_o=1 and busy_o=0 next cycle, no done_o; a following start_i is accepted normally.
5. reset_i asserted asynchronously while tx_o=0 mid-bit -> tx_o=1 before the next clock edge; all outputs at reset values.
6. DUMP_CHKSUM_EN, words 0x000000FF and 0x00000002 -> eight data bytes followed by trailer 0x01, then done_o.
